// File: rtl/lsu_mem_access_pkg.sv
// Shared LSU types: FSM state encoding, funct3 constants and lane/legality helpers.
package lsu_mem_access_pkg;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} lsu_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 4'h1;
      2'd1:    return 4'h3;
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] off, input logic hi);
    logic [7:0] be8;
    be8 = {4'b0, size_mask(f3)} << off;
    return hi ? be8[7:4] : be8[3:0];
  endfunction

  function automatic logic [31:0] lane_wd(input logic [2:0] f3, input logic [1:0] off,
                                          input logic [31:0] wdata, input logic hi);
    logic [3:0]  sm;
    logic [31:0] bm;
    logic [63:0] wd64;
    sm   = size_mask(f3);
    bm   = {{8{sm[3]}}, {8{sm[2]}}, {8{sm[1]}}, {8{sm[0]}}};
    wd64 = {32'b0, wdata & bm} << {off, 3'b000};
    return hi ? wd64[63:32] : wd64[31:0];
  endfunction

  function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
    if (we) return f3 > F3_W;
    return (f3 == 3'd3) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd1:    return off[0];
      2'd2:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic spans(input logic [2:0] f3, input logic [1:0] off);
    return ({1'b0, off} + size_bytes(f3)) > 3'd4;
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Request/response and word-memory bus between datapath, LSU and data memory.
interface lsu_mem_access_if #(parameter int ADDR_W = 32);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              fault;
  logic [31:0]       rdata;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [3:0]        m_be;
  logic [31:0]       m_wdata;
  logic [31:0]       m_rdata;

  modport master (output req, we, funct3, addr, wdata, m_rdata,
                  input  busy, done, fault, rdata, m_addr, m_we, m_be, m_wdata);
  modport slave  (input  req, we, funct3, addr, wdata, m_rdata,
                  output busy, done, fault, rdata, m_addr, m_we, m_be, m_wdata);
endinterface

// File: rtl/lsu_mem_access_load_ext.sv
// Load data alignment: shifts {hi, lo} down by the byte offset, then sign/zero-extends.
module lsu_load_ext
  import lsu_mem_access_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);
  logic [31:0] v;

  assign v = 32'(data >> {off, 3'b000});

  always_comb begin
    rdata = v;
    case (funct3)
      F3_B:    rdata = {{24{v[7]}}, v[7:0]};
      F3_H:    rdata = {{16{v[15]}}, v[15:0]};
      F3_BU:   rdata = {24'b0, v[7:0]};
      F3_HU:   rdata = {16'b0, v[15:0]};
      default: rdata = v;
    endcase
  end
endmodule

// File: rtl/lsu_mem_access.sv
// Multi-cycle RISC-V load/store unit over a word-organised memory.
// Define LSU_MISALIGNED_EN to split misaligned h/hu/w accesses across two words.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(parameter int ADDR_W = 32)
(
  input logic           clk,
  input logic           rst,
  lsu_mem_access_if.slave bus
);
  lsu_state_e        state;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [1:0]        off_q;
  logic              busy_r, done_r, fault_r, m_we_r;
  logic [3:0]        m_be_r;
  logic [31:0]       rdata_r, m_wdata_r;
  logic [ADDR_W-1:0] m_addr_r;
  logic [1:0]        off_in;
  logic              reject_in;
  logic [63:0]       ext_data;
  logic [31:0]       ext_rdata;

  assign off_in = bus.addr[1:0];

`ifdef LSU_MISALIGNED_EN
  logic        span_q;
  logic [3:0]  be_hi_q;
  logic [31:0] wd_hi_q, lo_q;
  assign reject_in = f3_illegal(bus.we, bus.funct3);
  assign ext_data  = (state == ACC1) ? {bus.m_rdata, lo_q} : {bus.m_rdata, bus.m_rdata};
`else
  assign reject_in = f3_illegal(bus.we, bus.funct3) | misaligned(bus.funct3, off_in);
  // Single-word loads never reach the upper half after the shift.
  assign ext_data  = {bus.m_rdata, bus.m_rdata};
`endif

  lsu_load_ext u_ext (.data(ext_data), .off(off_q), .funct3(f3_q), .rdata(ext_rdata));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      fault_r   <= 1'b0;
      rdata_r   <= '0;
      m_addr_r  <= '0;
      m_we_r    <= 1'b0;
      m_be_r    <= '0;
      m_wdata_r <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      off_q     <= '0;
`ifdef LSU_MISALIGNED_EN
      span_q    <= 1'b0;
      be_hi_q   <= '0;
      wd_hi_q   <= '0;
      lo_q      <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.req) begin
          we_q   <= bus.we;
          f3_q   <= bus.funct3;
          off_q  <= off_in;
          busy_r <= 1'b1;
          if (reject_in) begin
            state   <= DONE;
            done_r  <= 1'b1;
            fault_r <= 1'b1;
            rdata_r <= '0;
          end else begin
            state    <= ACC0;
            m_addr_r <= {bus.addr[ADDR_W-1:2], 2'b00};
            m_we_r   <= bus.we;
            m_be_r   <= bus.we ? lane_be(bus.funct3, off_in, 1'b0) : 4'h0;
            if (bus.we) m_wdata_r <= lane_wd(bus.funct3, off_in, bus.wdata, 1'b0);
`ifdef LSU_MISALIGNED_EN
            span_q  <= spans(bus.funct3, off_in);
            be_hi_q <= lane_be(bus.funct3, off_in, 1'b1);
            wd_hi_q <= lane_wd(bus.funct3, off_in, bus.wdata, 1'b1);
`endif
          end
        end
        ACC0: begin
`ifdef LSU_MISALIGNED_EN
          if (span_q) begin
            lo_q     <= bus.m_rdata;
            state    <= ACC1;
            m_addr_r <= m_addr_r + ADDR_W'(4);
            m_be_r   <= we_q ? be_hi_q : 4'h0;
            if (we_q) m_wdata_r <= wd_hi_q;
          end else
`endif
          begin
            state   <= DONE;
            done_r  <= 1'b1;
            fault_r <= 1'b0;
            if (!we_q) rdata_r <= ext_rdata;
            m_we_r  <= 1'b0;
            m_be_r  <= 4'h0;
          end
        end
`ifdef LSU_MISALIGNED_EN
        ACC1: begin
          state   <= DONE;
          done_r  <= 1'b1;
          fault_r <= 1'b0;
          if (!we_q) rdata_r <= ext_rdata;
          m_we_r  <= 1'b0;
          m_be_r  <= 4'h0;
        end
`endif
        DONE: begin
          state  <= IDLE;
          done_r <= 1'b0;
          busy_r <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.fault   = fault_r;
  assign bus.rdata   = rdata_r;
  assign bus.m_addr  = m_addr_r;
  assign bus.m_we    = m_we_r;
  assign bus.m_be    = m_be_r;
  assign bus.m_wdata = m_wdata_r;
endmodule

// File: tb/tb_lsu_mem_access.sv
// Bench for lsu_mem_access: byte-level reference memory, directed and random loads/stores.
module tb_lsu_mem_access;
`ifdef LSU_MISALIGNED_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   passes = 0;
  int   fails = 0;

  lsu_mem_access_if #(.ADDR_W(32)) bus ();
  lsu_mem_access #(.ADDR_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem [16];
  logic [7:0]  ref_mem [64];

  assign bus.m_rdata = mem[bus.m_addr[5:2]];

  always @(posedge clk)
    if (bus.m_we)
      for (int k = 0; k < 4; k++)
        if (bus.m_be[k]) mem[bus.m_addr[5:2]][8*k +: 8] <= bus.m_wdata[8*k +: 8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int sz_of(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit illegal_op(input logic w, input logic [2:0] f3);
    if (w) return f3 > 3'd2;
    return f3 inside {3'd3, 3'd6, 3'd7};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < sz_of(f3); i++) v[8*i +: 8] = ref_mem[int'((a + 32'(i)) & 32'd63)];
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic op(input string tag, input logic w, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] d, input bit hold);
    int          sz, off, exp_lat, lat;
    bit          flt;
    logic [31:0] exp_rd, exp_wd, wd0, rd_seen;
    logic [3:0]  exp_be, be0;
    logic        we_seen, busy0, fault_seen;
    sz      = sz_of(f3);
    off     = int'(a[1:0]);
    flt     = illegal_op(w, f3) || (!EN && (off % sz != 0));
    exp_lat = flt ? 1 : ((off + sz > 4) ? 3 : 2);
    exp_rd  = (!w && !flt) ? ref_load(f3, a) : 32'h0;
    exp_be  = '0;
    exp_wd  = '0;
    if (w && !flt)
      for (int k = 0; k < 4; k++)
        if (k >= off && k < off + sz) begin
          exp_be[k]        = 1'b1;
          exp_wd[8*k +: 8] = d[8*(k-off) +: 8];
        end

    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.funct3 = f3; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    be0 = bus.m_be; wd0 = bus.m_wdata; we_seen = bus.m_we; busy0 = bus.busy;
    if (hold) begin
      bus.we = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h0; bus.wdata = 32'h0BAD0BAD;
    end else bus.req = 1'b0;
    lat = 1;
    while (!bus.done && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      we_seen = we_seen | bus.m_we;
    end
    fault_seen = bus.fault;
    rd_seen    = bus.rdata;
    @(posedge clk); #1;
    bus.req = 1'b0;

    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_fault"}, 32'(fault_seen), 32'(flt));
    check({tag, "_busy"}, 32'(busy0), 32'd1);
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_mwe"}, 32'(we_seen), 32'(w && !flt));
    check({tag, "_be0"}, 32'(be0), 32'(exp_be));
    if (!w) check({tag, "_rdata"}, rd_seen, exp_rd);
    if (w && !flt) begin
      check({tag, "_wd0"}, wd0, exp_wd);
      for (int i = 0; i < sz; i++) ref_mem[int'((a + 32'(i)) & 32'd63)] = d[8*i +: 8];
    end
  endtask

  initial begin
    logic [31:0] word;
    for (int wi = 0; wi < 16; wi++) begin
      word = (wi == 1) ? 32'hdeadc0de : (wi == 2) ? 32'hdeadbeef :
             (wi == 3) ? 32'hc001c0de : $urandom;
      mem[wi] = word;
      for (int k = 0; k < 4; k++) ref_mem[4*wi + k] = word[8*k +: 8];
    end
    bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = '0; bus.wdata = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_fault", 32'(bus.fault), 32'd0);
    check("rst_mwe", 32'(bus.m_we), 32'd0);
    check("rst_mbe", 32'(bus.m_be), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_maddr", bus.m_addr, 32'd0);
    check("rst_mwdata", bus.m_wdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    op("lhu4",  1'b0, 3'd5, 32'h4, 32'h0, 1'b0);
    check("lhu4_value", bus.rdata, 32'h0000c0de);
    op("lh8",   1'b0, 3'd1, 32'h8, 32'h0, 1'b0);
    check("lh8_value", bus.rdata, 32'hffffbeef);
    op("lbuB",  1'b0, 3'd4, 32'hB, 32'h0, 1'b0);
    check("lbuB_value", bus.rdata, 32'h000000de);
    op("lbB",   1'b0, 3'd0, 32'hB, 32'h0, 1'b0);
    check("lbB_value", bus.rdata, 32'hffffffde);
    op("sb5",   1'b1, 3'd0, 32'h5, 32'h12345678, 1'b0);
    op("lw4",   1'b0, 3'd2, 32'h4, 32'h0, 1'b0);
    check("lw4_value", bus.rdata, 32'hdead78de);
    op("lw6",   1'b0, 3'd2, 32'h6, 32'h0, 1'b0);
    if (EN) check("lw6_value", bus.rdata, 32'hbeefdead);
    op("ld_f3_3", 1'b0, 3'd3, 32'h8, 32'h0, 1'b0);
    op("st_f3_4", 1'b1, 3'd4, 32'h8, 32'hffffffff, 1'b0);
    op("sh_mis", 1'b1, 3'd1, 32'h0F, 32'hA5A55A5A, 1'b0);
    op("lw_wrap", 1'b0, 3'd2, 32'hFFFFFFFE, 32'h0, 1'b0);
    op("hold", 1'b0, 3'd2, 32'h8, 32'h0, 1'b1);
    op("lw0_after_hold", 1'b0, 3'd2, 32'h0, 32'h0, 1'b0);
    op("sw_split", 1'b1, 3'd2, 32'h1D, 32'hCAFEF00D, 1'b0);
    op("lw_split", 1'b0, 3'd2, 32'h1C, 32'h0, 1'b0);
    op("lw_split2", 1'b0, 3'd2, 32'h20, 32'h0, 1'b0);

    // Asynchronous reset while a store is in its first access cycle.
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'd2; bus.addr = 32'h10; bus.wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    bus.req = 1'b0;
    check("rst_acc0_mwe_before", 32'(bus.m_we), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_acc0_mwe", 32'(bus.m_we), 32'd0);
    check("rst_acc0_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    op("lw_after_rst", 1'b0, 3'd2, 32'h10, 32'h0, 1'b0);

    for (int n = 0; n < 80; n++) begin
      logic [31:0] ra;
      ra = {($urandom_range(0, 3) == 0) ? 26'h3FFFFFF : 26'h0, 6'($urandom_range(0, 63))};
      op("rnd", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom, 1'b0);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
